// File: rtl/pixie_pkg.sv
// Shared Pixie (CDP1861) timing constants and DMA state encoding.
// The front end and the display back end both import this package.
package pixie_pkg;

    localparam int CYCLES_PER_LINE    = 14;
    localparam int PIXELS_PER_LINE    = CYCLES_PER_LINE * 8;
    localparam int LINES_PER_FRAME    = 262;
    localparam int FIRST_DISPLAY_LINE = 80;
    localparam int DISPLAY_LINES      = 128;
    localparam int BYTES_PER_LINE     = 8;
    localparam int FB_BYTES           = DISPLAY_LINES * BYTES_PER_LINE;
    localparam int FB_ADDR_W          = $clog2(FB_BYTES);
    localparam int DMA_START_CYCLE    = 2;
    localparam int DMA_LAST_CYCLE     = 11;
    localparam int INT_LINES          = 2;
    localparam int EF_LINES           = 4;

    localparam int MCYCLE_W = 4;
    localparam int LINE_W   = 9;

    typedef logic [MCYCLE_W-1:0] mcycle_t;
    typedef logic [LINE_W-1:0]   line_t;

    localparam mcycle_t MCYCLE_LAST     = mcycle_t'(CYCLES_PER_LINE - 1);
    // The request register is loaded one cycle early so it reads 1 while mcycle is DMA_START_CYCLE.
    localparam mcycle_t DMA_ARM_CYCLE   = mcycle_t'(DMA_START_CYCLE - 1);
    localparam mcycle_t DMA_LAST_MCYCLE = mcycle_t'(DMA_LAST_CYCLE);
    localparam mcycle_t DMA_CLOSE_CYCLE = mcycle_t'(DMA_LAST_CYCLE + 1);

    localparam line_t LINE_LAST    = line_t'(LINES_PER_FRAME - 1);
    localparam line_t DISP_FIRST   = line_t'(FIRST_DISPLAY_LINE);
    localparam line_t DISP_LAST    = line_t'(FIRST_DISPLAY_LINE + DISPLAY_LINES - 1);
    localparam line_t EF_TOP_FIRST = line_t'(FIRST_DISPLAY_LINE - EF_LINES);
    localparam line_t EF_BOT_FIRST = line_t'(FIRST_DISPLAY_LINE + DISPLAY_LINES - EF_LINES);
    localparam line_t INT_FIRST    = line_t'(FIRST_DISPLAY_LINE - INT_LINES);

    localparam logic [3:0] BYTE_LAST = 4'(BYTES_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } dma_state_t;

endpackage

// File: rtl/pixie_cycle_counter.sv
// Machine-cycle and scan-line counters with the frame-relative timing windows
// (EFx, interrupt, display lines) derived from the current line.
module pixie_cycle_counter
    import pixie_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    output logic [MCYCLE_W-1:0] mcycle,
    output logic [LINE_W-1:0]   line,
    output logic                line_end,
    output logic                frame_start,
    output logic                ef_window,
    output logic                int_window,
    output logic                display_line
);

    assign line_end = ce && (mcycle == MCYCLE_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcycle      <= '0;
            line        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (ce) begin
                if (mcycle == MCYCLE_LAST) begin
                    mcycle <= '0;
                    if (line == LINE_LAST) begin
                        line        <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        line <= line + 1'b1;
                    end
                end else begin
                    mcycle <= mcycle + 1'b1;
                end
            end
        end
    end

    assign ef_window    = ((line >= EF_TOP_FIRST) && (line < DISP_FIRST)) ||
                          ((line >= EF_BOT_FIRST) && (line <= DISP_LAST));
    assign int_window   = (line >= INT_FIRST) && (line < DISP_FIRST);
    assign display_line = (line >= DISP_FIRST) && (line <= DISP_LAST);

endmodule

// File: rtl/pixie_dp_front_end.sv
// CPU-facing half of the dual-port Pixie: frame timing toward the 1802
// (DMA-out requests, interrupt, EFx) and the framebuffer write port.
module pixie_dp_front_end
    import pixie_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 disp_on,
    input  logic                 disp_off,
    input  logic                 dma_ack,
    input  logic [7:0]           cpu_data,
    output logic                 dma_out_req,
    output logic                 int_n,
    output logic                 efx,
    output logic                 fb_wr_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_data,
    output logic                 frame_start
);

    logic [MCYCLE_W-1:0] mcycle;
    logic [LINE_W-1:0]   line;
    logic                line_end;
    logic                ef_window;
    logic                int_window;
    logic                display_line;

    logic                pending;
    logic                pending_next;
    logic                enabled;
    logic [3:0]          byte_idx;
    logic [6:0]          line_offset;
    logic                accept;
    dma_state_t          state;
    dma_state_t          state_next;

    pixie_cycle_counter u_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .mcycle       (mcycle),
        .line         (line),
        .line_end     (line_end),
        .frame_start  (frame_start),
        .ef_window    (ef_window),
        .int_window   (int_window),
        .display_line (display_line)
    );

    always_comb begin
        pending_next = pending;
        if (disp_on)  pending_next = 1'b1;
        if (disp_off) pending_next = 1'b0;
    end

    // enabled only changes across a line boundary so every line runs under one state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= 1'b0;
            enabled <= 1'b0;
        end else if (ce) begin
            pending <= pending_next;
            if (line_end) enabled <= pending_next;
        end
    end

    assign line_offset = 7'(line - DISP_FIRST);
    assign accept      = ce && (state == REQ) && dma_ack && (mcycle <= DMA_LAST_MCYCLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (ce && (mcycle == DMA_ARM_CYCLE) && display_line && enabled)
                      state_next = REQ;
            REQ:  if ((accept && (byte_idx == BYTE_LAST)) ||
                      (ce && (mcycle == DMA_CLOSE_CYCLE)))
                      state_next = DONE;
            DONE: if (line_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            fb_wr_en <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            state    <= state_next;
            fb_wr_en <= accept;
            if (accept) begin
                fb_addr  <= {line_offset, byte_idx[2:0]};
                fb_data  <= cpu_data;
                byte_idx <= byte_idx + 1'b1;
            end else if (line_end) begin
                byte_idx <= '0;
            end
        end
    end

    assign dma_out_req = (state == REQ);
    assign int_n       = !(enabled && int_window);
    assign efx         = ef_window;

endmodule

// File: tb/tb_pixie_dp_front_end.sv
// Directed bench for pixie_dp_front_end: frame timing, DMA writes,
// partial lines, display on/off and mid-DMA reset.
module tb_pixie_dp_front_end;

    logic       clk;
    logic       reset_n;
    logic       ce;
    logic       disp_on;
    logic       disp_off;
    logic       dma_ack;
    logic [7:0] cpu_data;
    logic       dma_out_req;
    logic       int_n;
    logic       efx;
    logic       fb_wr_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       frame_start;

    pixie_dp_front_end dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .dma_ack     (dma_ack),
        .cpu_data    (cpu_data),
        .dma_out_req (dma_out_req),
        .int_n       (int_n),
        .efx         (efx),
        .fb_wr_en    (fb_wr_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    int m_line = 0;
    int m_mc   = 0;
    int prev_mc = 0;
    int tb_byte = 0;
    int quota80 = 8;

    int req_count, int_low_count, efx_count, fs_count, fs_pos;
    int first_req_pos, first_int_low, last_int_low, int_at_80;
    int req_at_80_12, req_at_80_13;
    logic [9:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         wr_mc[$];

    task automatic check_output(input string tag, input int observed, input int expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic clear_monitors();
        req_count = 0; int_low_count = 0; efx_count = 0; fs_count = 0; fs_pos = -1;
        first_req_pos = -1; first_int_low = -1; last_int_low = -1; int_at_80 = -1;
        req_at_80_12 = -1; req_at_80_13 = -1;
        wr_addr.delete(); wr_data.delete(); wr_mc.delete();
    endtask

    // one clk: update the position model at the edge, sample and drive at the falling edge
    task automatic apply_stimulus();
        int pos;
        @(posedge clk);
        prev_mc = m_mc;
        if (!reset_n) begin
            m_line = 0; m_mc = 0; tb_byte = 0;
        end else if (ce) begin
            if (dma_ack && dma_out_req) tb_byte++;
            if (m_mc == 13) begin
                m_mc = 0; tb_byte = 0;
                m_line = (m_line == 261) ? 0 : m_line + 1;
            end else begin
                m_mc++;
            end
        end
        @(negedge clk);
        pos = m_line * 16 + m_mc;
        if (dma_out_req) begin
            req_count++;
            if (first_req_pos < 0) first_req_pos = pos;
        end
        if (!int_n) begin
            int_low_count++;
            if (first_int_low < 0) first_int_low = pos;
            last_int_low = pos;
        end
        if (efx) efx_count++;
        if (frame_start) begin fs_count++; fs_pos = pos; end
        if (fb_wr_en) begin
            wr_addr.push_back(fb_addr);
            wr_data.push_back(fb_data);
            wr_mc.push_back(prev_mc);
        end
        if (pos == 80 * 16)      int_at_80    = int'(int_n);
        if (pos == 80 * 16 + 12) req_at_80_12 = int'(dma_out_req);
        if (pos == 80 * 16 + 13) req_at_80_13 = int'(dma_out_req);
        dma_ack  = dma_out_req && (m_line != 80 || tb_byte < quota80);
        cpu_data = 8'((m_line - 80) * 8 + tb_byte);
    endtask

    task automatic run_to(input int line_t, input int mc_t);
        int guard = 0;
        do begin
            apply_stimulus();
            guard++;
        end while (!(m_line == line_t && m_mc == mc_t) && guard < 10000);
        if (guard >= 10000) begin
            check_count++;
            $error("[TB] FAIL run_to: position %0d/%0d required %0d/%0d", m_line, m_mc, line_t, mc_t);
        end
    endtask

    function automatic int get_addr(input int i);
        return (i < wr_addr.size()) ? int'(wr_addr[i]) : -1;
    endfunction

    initial begin
        int bad_addr, bad_data, bad_mc;
        reset_n = 1'b0; ce = 1'b1; disp_on = 1'b0; disp_off = 1'b0;
        dma_ack = 1'b0; cpu_data = 8'h00;
        clear_monitors();

        // reset state
        apply_stimulus();
        apply_stimulus();
        check_output("rst_req", int'(dma_out_req), 0);
        check_output("rst_int_n", int'(int_n), 1);
        check_output("rst_efx", int'(efx), 0);
        check_output("rst_wr_en", int'(fb_wr_en), 0);
        check_output("rst_addr", int'(fb_addr), 0);
        check_output("rst_data", int'(fb_data), 0);
        check_output("rst_frame_start", int'(frame_start), 0);

        // one frame with the display off
        reset_n = 1'b1;
        clear_monitors();
        for (int i = 0; i < 3668; i++) apply_stimulus();
        check_output("off_req_count", req_count, 0);
        check_output("off_int_low", int_low_count, 0);
        check_output("off_efx_count", efx_count, 112);
        check_output("off_fs_count", fs_count, 1);
        check_output("off_fs_pos", fs_pos, 0);

        // display on, full DMA frame
        disp_on = 1'b1;
        apply_stimulus();
        disp_on = 1'b0;
        clear_monitors();
        run_to(210, 0);
        check_output("full_wr_count", wr_addr.size(), 1024);
        bad_addr = 0; bad_data = 0; bad_mc = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (int'(wr_addr[i]) != i) bad_addr++;
            if (wr_data[i] != 8'(i)) bad_data++;
            if (wr_mc[i] != 2 + (i % 8)) bad_mc++;
        end
        check_output("full_addr_order", bad_addr, 0);
        check_output("full_data", bad_data, 0);
        check_output("full_write_mcycle", bad_mc, 0);
        check_output("full_last_addr", get_addr(1023), 1023);
        check_output("full_first_req", first_req_pos, 80 * 16 + 2);
        check_output("int_low_count", int_low_count, 28);
        check_output("int_first_low", first_int_low, 78 * 16);
        check_output("int_last_low", last_int_low, 79 * 16 + 13);
        check_output("int_high_at_80", int_at_80, 1);

        // line 80 acknowledges only three bytes
        quota80 = 3;
        clear_monitors();
        run_to(83, 0);
        quota80 = 8;
        check_output("part_wr_count", wr_addr.size(), 19);
        check_output("part_addr0", get_addr(0), 0);
        check_output("part_addr2", get_addr(2), 2);
        check_output("part_addr3", get_addr(3), 8);
        check_output("part_data3", (wr_data.size() > 3) ? int'(wr_data[3]) : -1, 8);
        check_output("part_req_mc12", req_at_80_12, 1);
        check_output("part_req_mc13", req_at_80_13, 0);

        // display off mid-line 100
        run_to(100, 0);
        clear_monitors();
        run_to(100, 5);
        disp_off = 1'b1;
        apply_stimulus();
        disp_off = 1'b0;
        run_to(101, 0);
        check_output("off100_wr_count", wr_addr.size(), 8);
        check_output("off100_first", get_addr(0), 160);
        check_output("off100_last", get_addr(7), 167);
        clear_monitors();
        run_to(210, 0);
        check_output("off101_req_count", req_count, 0);
        check_output("off101_wr_count", wr_addr.size(), 0);

        // simultaneous on and off: off wins
        disp_on = 1'b1; disp_off = 1'b1;
        apply_stimulus();
        disp_on = 1'b0; disp_off = 1'b0;
        clear_monitors();
        run_to(100, 0);
        check_output("both_req_count", req_count, 0);
        check_output("both_int_low", int_low_count, 0);

        // reset during an active DMA request
        disp_on = 1'b1;
        apply_stimulus();
        disp_on = 1'b0;
        run_to(90, 4);
        check_output("pre_rst_req", int'(dma_out_req), 1);
        reset_n = 1'b0;
        apply_stimulus();
        check_output("mid_rst_req", int'(dma_out_req), 0);
        check_output("mid_rst_wr_en", int'(fb_wr_en), 0);
        check_output("mid_rst_int_n", int'(int_n), 1);
        check_output("mid_rst_efx", int'(efx), 0);
        reset_n = 1'b1;
        clear_monitors();
        run_to(76, 0);
        check_output("restart_efx_76", int'(efx), 1);
        run_to(0, 0);
        check_output("restart_req_count", req_count, 0);
        check_output("restart_wr_count", wr_addr.size(), 0);
        check_output("restart_fs_count", fs_count, 1);
        check_output("restart_int_low", int_low_count, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
